channel_rx_buffer: RTL and testbench

- Receiving end of one router-to-router (or local-to-router) channel.
- Accepts items pushed by the upstream routing logic via ena/item and throttles it with busy.
- Buffers items in a first-word-fall-through circular FIFO and presents them to the downstream routing logic as item/empty, popped by read.
- One instance per input direction (N, E, S, W, L) per router.

---
 rtl/channel_rx_buffer.sv | 94 +++++++++
 tb/tb_channel_rx_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/channel_rx_buffer.sv
// Receiving end of one router channel: a first-word-fall-through circular
// FIFO with registered back-pressure (busy) and sticky overflow/underflow flags.

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 6
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module channel_rx_buffer #(
  parameter int ITEM_W     = `HDR_SZ + `PL_SZ + `ADDR_SZ,
  parameter int DEPTH      = 4,
  parameter int BUSY_SLACK = 0,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [ITEM_W-1:0] item_in,
  output logic              busy,
  input  logic              read,
  output logic [ITEM_W-1:0] item_out,
  output logic              empty,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] L_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_BUSY_TH = CNT_W'(DEPTH - BUSY_SLACK);
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] L_LAST    = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);

  logic [ITEM_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_occ;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Status and handshake decode; busy/empty come from registered occupancy only,
  // so nothing here is combinational from ena or read to busy.
  always_comb begin
    w_full    = (r_occ == L_DEPTH);
    w_empty   = (r_occ == '0);
    w_pop     = read & ~w_empty;
    w_push    = ena & (~w_full | w_pop);
    busy      = (r_occ >= L_BUSY_TH);
    empty     = w_empty;
    occupancy = r_occ;
    overflow  = r_overflow;
    underflow = r_underflow;
    item_out  = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  // Pointer, occupancy and sticky error flag state; reset wins over any strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + L_CNT_ONE;
        2'b01:   r_occ <= r_occ - L_CNT_ONE;
        default: r_occ <= r_occ;
      endcase
      if (ena & ~w_push)   r_overflow  <= 1'b1;
      if (read & w_empty)  r_underflow <= 1'b1;
    end
  end

  // Item storage; contents are not cleared, visibility is governed by occupancy.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= item_in;
  end

endmodule

// File: tb/tb_channel_rx_buffer.sv
// Bench for channel_rx_buffer: a vector table on a DEPTH=4 instance and a
// scoreboard-driven stream (wrap-around, random traffic) on a DEPTH=3 instance.
`timescale 1ns/1ps

module tb_channel_rx_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        r4_reset, r4_ena, r4_read;
  logic [11:0] r4_item;
  logic        o4_busy, o4_empty, o4_ovf, o4_udf;
  logic [11:0] o4_item;
  logic [2:0]  o4_occ;

  channel_rx_buffer #(.ITEM_W(12), .DEPTH(4), .BUSY_SLACK(0), .CNT_W(3)) u4 (
    .clk(clk), .reset(r4_reset), .ena(r4_ena), .item_in(r4_item), .busy(o4_busy),
    .read(r4_read), .item_out(o4_item), .empty(o4_empty), .occupancy(o4_occ),
    .overflow(o4_ovf), .underflow(o4_udf)
  );

  // DEPTH=3 instance
  logic        r3_reset, r3_ena, r3_read;
  logic [11:0] r3_item;
  logic        o3_busy, o3_empty, o3_ovf, o3_udf;
  logic [11:0] o3_item;
  logic [2:0]  o3_occ;

  channel_rx_buffer #(.ITEM_W(12), .DEPTH(3), .BUSY_SLACK(0), .CNT_W(3)) u3 (
    .clk(clk), .reset(r3_reset), .ena(r3_ena), .item_in(r3_item), .busy(o3_busy),
    .read(r3_read), .item_out(o3_item), .empty(o3_empty), .occupancy(o3_occ),
    .overflow(o3_ovf), .underflow(o3_udf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en, rd;
    logic [11:0] din;
    logic        e_empty, e_busy;
    logic [2:0]  e_occ;
    logic [11:0] e_out;
    logic        e_ovf, e_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, en, rd, input logic [11:0] din,
                     input logic e_empty, e_busy, input logic [2:0] e_occ,
                     input logic [11:0] e_out, input logic e_ovf, e_udf);
    vec_t v;
    v.rst = rst; v.en = en; v.rd = rd; v.din = din;
    v.e_empty = e_empty; v.e_busy = e_busy; v.e_occ = e_occ;
    v.e_out = e_out; v.e_ovf = e_ovf; v.e_udf = e_udf;
    vecs.push_back(v);
  endtask

  // Scoreboard model for the DEPTH=3 instance
  logic [11:0] sb[$];
  logic        m_ovf, m_udf;
  int          step3 = 0;

  task automatic cyc3(input logic rst, en, rd, input logic [11:0] din);
    int occ_before;
    bit pop, push;
    r3_reset = rst; r3_ena = en; r3_read = rd; r3_item = din;
    if (rst) begin
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      occ_before = sb.size();
      pop  = rd && (occ_before != 0);
      push = en && ((occ_before < 3) || pop);
      if (pop) chk("d3_pop_item", step3, 32'(o3_item), 32'(sb.pop_front()));
      if (en && !push) m_ovf = 1'b1;
      if (rd && occ_before == 0) m_udf = 1'b1;
      if (push) sb.push_back(din);
    end
    @(posedge clk);
    @(negedge clk);
    chk("d3_occ",   step3, 32'(o3_occ),   32'(sb.size()));
    chk("d3_empty", step3, 32'(o3_empty), 32'(sb.size() == 0));
    chk("d3_busy",  step3, 32'(o3_busy),  32'(sb.size() >= 3));
    chk("d3_ovf",   step3, 32'(o3_ovf),   32'(m_ovf));
    chk("d3_udf",   step3, 32'(o3_udf),   32'(m_udf));
    chk("d3_head",  step3, 32'(o3_item),  (sb.size() == 0) ? 32'h0 : 32'(sb[0]));
    step3++;
  endtask

  initial begin
    r4_reset = 1'b1; r4_ena = 1'b0; r4_read = 1'b0; r4_item = '0;
    r3_reset = 1'b1; r3_ena = 1'b0; r3_read = 1'b0; r3_item = '0;

    //  rst en rd din      empty busy occ out      ovf udf
    add(1, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(1, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 1, 0, 12'h2A5, 0, 0, 1, 12'h2A5, 0, 0);   // FWFT: visible next cycle
    add(0, 0, 1, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 1, 0, 12'h011, 0, 0, 1, 12'h011, 0, 0);   // fill
    add(0, 1, 0, 12'h022, 0, 0, 2, 12'h011, 0, 0);
    add(0, 1, 0, 12'h033, 0, 0, 3, 12'h011, 0, 0);
    add(0, 1, 0, 12'h044, 0, 1, 4, 12'h011, 0, 0);
    add(0, 1, 0, 12'h055, 0, 1, 4, 12'h011, 1, 0);   // dropped
    add(0, 0, 1, 12'h000, 0, 0, 3, 12'h022, 1, 0);
    add(0, 0, 1, 12'h000, 0, 0, 2, 12'h033, 1, 0);
    add(0, 0, 1, 12'h000, 0, 0, 1, 12'h044, 1, 0);
    add(0, 0, 1, 12'h000, 1, 0, 0, 12'h000, 1, 0);
    add(1, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 1, 0, 12'h011, 0, 0, 1, 12'h011, 0, 0);
    add(0, 1, 0, 12'h022, 0, 0, 2, 12'h011, 0, 0);
    add(0, 1, 0, 12'h033, 0, 0, 3, 12'h011, 0, 0);
    add(0, 1, 0, 12'h044, 0, 1, 4, 12'h011, 0, 0);
    add(0, 1, 1, 12'h055, 0, 1, 4, 12'h022, 0, 0);   // full with push+pop
    add(0, 0, 1, 12'h000, 0, 0, 3, 12'h033, 0, 0);
    add(0, 0, 1, 12'h000, 0, 0, 2, 12'h044, 0, 0);
    add(0, 0, 1, 12'h000, 0, 0, 1, 12'h055, 0, 0);
    add(0, 0, 1, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 0, 1, 12'h000, 1, 0, 0, 12'h000, 0, 1);   // underflow
    add(0, 1, 0, 12'h066, 0, 0, 1, 12'h066, 0, 1);
    add(0, 1, 0, 12'h077, 0, 0, 2, 12'h066, 0, 1);
    add(1, 1, 0, 12'h088, 1, 0, 0, 12'h000, 0, 0);   // reset wins over ena
    add(0, 0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      r4_reset = vecs[i].rst; r4_ena = vecs[i].en; r4_read = vecs[i].rd; r4_item = vecs[i].din;
      @(posedge clk);
      @(negedge clk);
      chk("t4_empty", i, 32'(o4_empty), 32'(vecs[i].e_empty));
      chk("t4_busy",  i, 32'(o4_busy),  32'(vecs[i].e_busy));
      chk("t4_occ",   i, 32'(o4_occ),   32'(vecs[i].e_occ));
      chk("t4_item",  i, 32'(o4_item),  32'(vecs[i].e_out));
      chk("t4_ovf",   i, 32'(o4_ovf),   32'(vecs[i].e_ovf));
      chk("t4_udf",   i, 32'(o4_udf),   32'(vecs[i].e_udf));
    end
    r4_reset = 1'b0; r4_ena = 1'b0; r4_read = 1'b0;

    // DEPTH=3 wrap-around stream, occupancy held at 1-2
    cyc3(1, 0, 0, 12'h000);
    cyc3(1, 0, 0, 12'h000);
    cyc3(0, 1, 0, 12'h001);
    cyc3(0, 1, 0, 12'h002);
    for (int k = 3; k <= 10; k++) cyc3(0, 1, 1, 12'(k));
    cyc3(0, 0, 1, 12'h000);
    cyc3(0, 0, 1, 12'h000);
    chk("wrap_ovf", 0, 32'(o3_ovf), 32'h0);
    chk("wrap_udf", 0, 32'(o3_udf), 32'h0);
    chk("wrap_empty", 0, 32'(o3_empty), 32'h1);

    // DEPTH=3 random traffic, including overflow, underflow and resets
    for (int k = 0; k < 400; k++) begin
      cyc3(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0 ? 1 : 0) | 1'($urandom_range(0, 3) == 0 ? 1 : 0),
           12'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
